// File: rtl/uart_rx_core.sv
// UART receive engine: synchronises serial_in, frames 5..8 bit characters and reports status.
// Optional build macro UART_RX_MAJORITY_EN enables 2-of-3 majority sampling around each sample point.
module uart_rx_core #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PERIOD  = 4
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        serial_in,
  input  logic [3:0]  data_size,
  input  logic [13:0] bit_period,
  input  logic        data_read,
  output logic [7:0]  rx_data,
  output logic        data_ready,
  output logic        overrun_error,
  output logic        framing_error
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t                 state, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   line, line_prev, sample_bit;
  logic [13:0]            timer_q, timer_d, period_q, period_d, period_in;
  logic [3:0]             bit_cnt_q, bit_cnt_d, size_q, size_d, size_in;
  logic [7:0]             shift_q, shift_d, rx_data_d;
  logic                   data_ready_d, overrun_d, framing_d, tick;

  assign line = sync_q[SYNC_STAGES-1];
  assign tick = (timer_q == 14'd0);

  assign period_in = (bit_period < 14'(MIN_PERIOD)) ? 14'(MIN_PERIOD) : bit_period;
  assign size_in   = (data_size < 4'd5) ? 4'd5 : ((data_size > 4'd8) ? 4'd8 : data_size);

`ifdef UART_RX_MAJORITY_EN
  // line_prev is the nominal sample point; line_prev2 and line are its neighbours.
  logic line_prev2;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) line_prev2 <= 1'b1;
    else        line_prev2 <= line_prev;
  end
  assign sample_bit = (line_prev2 & line_prev) | (line_prev2 & line) | (line_prev & line);
`else
  assign sample_bit = line;
`endif

  always_comb begin
    state_d      = state;
    timer_d      = timer_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    period_d     = period_q;
    size_d       = size_q;
    rx_data_d    = rx_data;
    data_ready_d = data_ready & ~data_read;
    overrun_d    = overrun_error & ~data_read;
    framing_d    = framing_error & ~data_read;

    case (state)
      IDLE: begin
        if (line_prev && !line) begin
          state_d   = START;
          shift_d   = 8'h00;
          bit_cnt_d = 4'd0;
          period_d  = period_in;
          size_d    = size_in;
          timer_d   = (period_in >> 1) - 14'd1;
        end
      end
      START: begin
        if (!tick)            timer_d = timer_q - 14'd1;
        else if (!sample_bit) begin
          state_d = DATA;
          timer_d = period_q - 14'd1;
        end else              state_d = IDLE;
      end
      DATA: begin
        if (!tick) timer_d = timer_q - 14'd1;
        else begin
          shift_d   = {sample_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          timer_d   = period_q - 14'd1;
          if (bit_cnt_q == size_q - 4'd1) state_d = STOP;
        end
      end
      STOP: begin
        if (!tick) timer_d = timer_q - 14'd1;
        else if (sample_bit) begin
          // A load coinciding with data_read counts as consumed, so no overrun.
          rx_data_d    = shift_q;
          data_ready_d = 1'b1;
          framing_d    = 1'b0;
          if (data_ready && !data_read) overrun_d = 1'b1;
          state_d      = IDLE;
        end else begin
          framing_d = 1'b1;
          state_d   = WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (line) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q        <= '1;
      line_prev     <= 1'b1;
      timer_q       <= 14'd0;
      bit_cnt_q     <= 4'd0;
      shift_q       <= 8'h00;
      period_q      <= 14'(MIN_PERIOD);
      size_q        <= 4'd5;
      rx_data       <= 8'h00;
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], serial_in};
      line_prev     <= line;
      timer_q       <= timer_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      period_q      <= period_d;
      size_q        <= size_d;
      rx_data       <= rx_data_d;
      data_ready    <= data_ready_d;
      overrun_error <= overrun_d;
      framing_error <= framing_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: scoreboard of expected status, one task per scenario.
module tb_uart_rx_core;

  logic        clk, n_rst, serial_in, data_read;
  logic [3:0]  data_size;
  logic [13:0] bit_period;
  logic [7:0]  rx_data;
  logic        data_ready, overrun_error, framing_error;

  typedef struct {
    logic [7:0] data;
    logic       ready;
    logic       ovr;
    logic       fe;
  } exp_t;

  exp_t        sb[$];
  int          tests_run = 0;
  int          tests_failed = 0;

  uart_rx_core #(.SYNC_STAGES(2), .MIN_PERIOD(4)) dut (
    .clk(clk), .n_rst(n_rst), .serial_in(serial_in), .data_size(data_size),
    .bit_period(bit_period), .data_read(data_read), .rx_data(rx_data),
    .data_ready(data_ready), .overrun_error(overrun_error), .framing_error(framing_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] align(input logic [7:0] data, input int n);
    logic [7:0] v;
    v = data << (8 - n);
    return v;
  endfunction

  function automatic logic [10:0] observed();
    return {rx_data, data_ready, overrun_error, framing_error};
  endfunction

  function automatic logic [10:0] pop_expected();
    exp_t e;
    e = sb.pop_front();
    return {e.data, e.ready, e.ovr, e.fe};
  endfunction

  task automatic push_expected(input logic [7:0] d, input logic r, input logic o, input logic f);
    exp_t e;
    e.data = d; e.ready = r; e.ovr = o; e.fe = f;
    sb.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] data, input int n, input int p, input logic stop_bit);
    serial_in = 1'b0;
    wait_cycles(p);
    for (int i = 0; i < n; i++) begin
      serial_in = data[i];
      wait_cycles(p);
    end
    serial_in = stop_bit;
    wait_cycles(p);
  endtask

  task automatic pulse_read();
    data_read = 1'b1;
    wait_cycles(1);
    data_read = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] obs, expv;
    n_rst = 1'b0; serial_in = 1'b1; data_read = 1'b0;
    data_size = 4'd8; bit_period = 14'd10;
    wait_cycles(3);
    push_expected(8'h00, 1'b0, 1'b0, 1'b0);
    obs = observed(); expv = pop_expected(); tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("[TB] FAIL reset_values: got %h expected %h", obs, expv);
    end
    n_rst = 1'b1;
    wait_cycles(5);
  endtask

  task automatic test_basic_8bit();
    logic [10:0] obs, expv;
    push_expected(8'hA5, 1'b1, 1'b0, 1'b0);
    fork
      send_frame(8'hA5, 8, 10, 1'b1);
      begin
        wait_cycles(97);
        tests_run++;
        if (data_ready !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL basic_early: data_ready got %b expected 0 at cycle 97", data_ready);
        end
        wait_cycles(1);
        obs = observed(); expv = pop_expected(); tests_run++;
        if (obs !== expv) begin
          tests_failed++;
          $display("[TB] FAIL basic_latency98: got %h expected %h", obs, expv);
        end
      end
    join
    wait_cycles(3);
  endtask

  task automatic test_5bit_read();
    logic [10:0] obs, expv;
    pulse_read();
    data_size = 4'd5;
    push_expected(align(8'h15, 5), 1'b1, 1'b0, 1'b0);
    fork
      send_frame(8'h15, 5, 10, 1'b1);
      begin
        wait_cycles(15);
        data_size = 4'd8; bit_period = 14'd20;
      end
    join
    wait_cycles(2);
    bit_period = 14'd10;
    obs = observed(); expv = pop_expected(); tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("[TB] FAIL five_bit: got %h expected %h", obs, expv);
    end
    pulse_read();
    tests_run++;
    if (data_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL read_clear: data_ready got %b expected 0", data_ready);
    end
    wait_cycles(3);
  endtask

  task automatic test_back_to_back_overrun();
    logic [10:0] obs, expv;
    push_expected(8'h3C, 1'b1, 1'b0, 1'b0);
    push_expected(8'hC3, 1'b1, 1'b1, 1'b0);
    send_frame(8'h3C, 8, 10, 1'b1);
    obs = observed(); expv = pop_expected(); tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("[TB] FAIL b2b_first: got %h expected %h", obs, expv);
    end
    send_frame(8'hC3, 8, 10, 1'b1);
    obs = observed(); expv = pop_expected(); tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("[TB] FAIL b2b_overrun: got %h expected %h", obs, expv);
    end
    pulse_read();
    push_expected(8'hC3, 1'b0, 1'b0, 1'b0);
    obs = observed(); expv = pop_expected(); tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("[TB] FAIL overrun_clear: got %h expected %h", obs, expv);
    end
    wait_cycles(3);
  endtask

  task automatic test_framing();
    logic [10:0] obs, expv;
    push_expected(8'hC3, 1'b0, 1'b0, 1'b1);
    push_expected(8'hC3, 1'b0, 1'b0, 1'b1);
    push_expected(8'h12, 1'b1, 1'b0, 1'b0);
    send_frame(8'h55, 8, 10, 1'b0);
    wait_cycles(30);
    serial_in = 1'b1;
    wait_cycles(5);
    obs = observed(); expv = pop_expected(); tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("[TB] FAIL framing_set: got %h expected %h", obs, expv);
    end
    wait_cycles(20);
    obs = observed(); expv = pop_expected(); tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("[TB] FAIL framing_no_spurious: got %h expected %h", obs, expv);
    end
    send_frame(8'h12, 8, 10, 1'b1);
    wait_cycles(2);
    obs = observed(); expv = pop_expected(); tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("[TB] FAIL framing_recover: got %h expected %h", obs, expv);
    end
    wait_cycles(3);
  endtask

  task automatic test_false_start();
    logic [10:0] obs, expv;
    push_expected(8'h12, 1'b1, 1'b0, 1'b0);
    push_expected(8'h5A, 1'b1, 1'b0, 1'b0);
    serial_in = 1'b0;
    wait_cycles(3);
    serial_in = 1'b1;
    wait_cycles(20);
    obs = observed(); expv = pop_expected(); tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("[TB] FAIL false_start_flags: got %h expected %h", obs, expv);
    end
    pulse_read();
    send_frame(8'h5A, 8, 10, 1'b1);
    wait_cycles(2);
    obs = observed(); expv = pop_expected(); tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("[TB] FAIL false_start_next: got %h expected %h", obs, expv);
    end
    wait_cycles(3);
  endtask

  task automatic test_read_collision();
    logic [10:0] obs, expv;
    push_expected(8'h33, 1'b1, 1'b0, 1'b0);
    fork
      send_frame(8'h33, 8, 10, 1'b1);
      begin
        wait_cycles(97);
        data_read = 1'b1;
        wait_cycles(1);
        data_read = 1'b0;
      end
    join
    wait_cycles(2);
    obs = observed(); expv = pop_expected(); tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("[TB] FAIL load_vs_read: got %h expected %h", obs, expv);
    end
    wait_cycles(3);
  endtask

  task automatic test_clamp();
    logic [10:0] obs, expv;
    pulse_read();
    bit_period = 14'd1; data_size = 4'd15;
    push_expected(8'h6B, 1'b1, 1'b0, 1'b0);
    send_frame(8'h6B, 8, 4, 1'b1);
    wait_cycles(2);
    obs = observed(); expv = pop_expected(); tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("[TB] FAIL clamp_p4_n8: got %h expected %h", obs, expv);
    end
    pulse_read();
    bit_period = 14'd4; data_size = 4'd3;
    push_expected(align(8'h0B, 5), 1'b1, 1'b0, 1'b0);
    send_frame(8'h0B, 5, 4, 1'b1);
    wait_cycles(2);
    obs = observed(); expv = pop_expected(); tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("[TB] FAIL clamp_n5: got %h expected %h", obs, expv);
    end
    bit_period = 14'd10; data_size = 4'd8;
    wait_cycles(3);
  endtask

`ifdef UART_RX_MAJORITY_EN
  task automatic test_majority_glitch();
    logic [10:0] obs, expv;
    pulse_read();
    push_expected(8'h00, 1'b1, 1'b0, 1'b0);
    serial_in = 1'b0;
    wait_cycles(10);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        wait_cycles(5);
        serial_in = 1'b1;
        wait_cycles(1);
        serial_in = 1'b0;
        wait_cycles(4);
      end else begin
        wait_cycles(10);
      end
    end
    serial_in = 1'b1;
    wait_cycles(12);
    obs = observed(); expv = pop_expected(); tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("[TB] FAIL majority_glitch: got %h expected %h", obs, expv);
    end
    wait_cycles(3);
  endtask
`endif

  task automatic test_reset_midframe();
    logic [10:0] obs, expv;
    push_expected(8'h00, 1'b0, 1'b0, 1'b0);
    push_expected(8'h81, 1'b1, 1'b0, 1'b0);
    serial_in = 1'b0;
    wait_cycles(10);
    for (int i = 0; i < 4; i++) begin
      serial_in = 1'b1;
      wait_cycles(10);
    end
    wait_cycles(5);
    n_rst = 1'b0;
    #1;
    obs = observed(); expv = pop_expected(); tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("[TB] FAIL reset_midframe: got %h expected %h", obs, expv);
    end
    wait_cycles(2);
    serial_in = 1'b1;
    n_rst = 1'b1;
    wait_cycles(20);
    send_frame(8'h81, 8, 10, 1'b1);
    wait_cycles(2);
    obs = observed(); expv = pop_expected(); tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("[TB] FAIL after_reset_frame: got %h expected %h", obs, expv);
    end
  endtask

  initial begin
    test_reset();
    test_basic_8bit();
    test_5bit_read();
    test_back_to_back_overrun();
    test_framing();
    test_false_start();
    test_read_collision();
    test_clamp();
`ifdef UART_RX_MAJORITY_EN
    test_majority_glitch();
`endif
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
